data_memory_line: RTL and testbench
===================================

# data_memory_line

Off-chip data memory model for the data-cache refill/write-back path. It is a line-granular (256-bit) store with a fixed, parameterised access latency and a single-cycle acknowledge. It sits directly downstream of the data cache and consumes the cache's memory-side request (enable, write, line address, line data). It returns the read line and an acknowledge after `LATENCY` cycles.

## Interface
- `LATENCY`, 10: cycles from request acceptance to `ack_o`; legal range ≥ 1.
- `DEPTH`, 512: number of 256-bit lines (16 KiB); power of two.
- `clk_i` in 1: single clock; all state changes on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `addr_i` in 32: byte address; bits [4:0] ignored; line index = addr_i[5+$clog2(DEPTH)-1:5].
- `data_i` in 256: write line data.
- `enable_i` in 1: request valid; held high by requester until it sees `ack_o`.
- `write_i` in 1: 1 = write line, 0 = read line.
- `ack_o` out 1: one-cycle completion pulse.
- `data_o` out 256: last read line; held stable until the next read completes.

## Operation
- FSM states:
  - IDLE:
    - if `enable_i` is high at an edge, latch index, `data_i` and `write_i`; load `cnt` = `LATENCY`-1; go to BUSY.
  - BUSY:
    - if `cnt` != 0, decrement.
    - if `cnt` == 0, go to ACK and set `ack_o` <= 1.
    - On that same edge, a write commits the latched data to line[index]; a read loads `data_o` <= line[index].
  - ACK:
    - `ack_o` <= 0; go to IDLE.
    - `enable_i` is ignored in this state, even if still high.
- Request fields are latched at acceptance. Changes on `addr_i`, `data_i` or `write_i` during BUSY or ACK have no effect.
- Deasserting `enable_i` during BUSY does not abort the request; it completes and acks normally.
- A write completion leaves `data_o` unchanged.
- Addresses beyond `DEPTH` lines wrap: upper address bits are dropped, so line `DEPTH` aliases line 0.
- Storage is not cleared by reset; contents are undefined until written.
- `cnt` width is $clog2(`LATENCY`) with a minimum of 1 bit. No other arithmetic.

## Timing
- Reset values:
  - state = IDLE
  - `ack_o` = 0
  - `data_o` = 0
  - `cnt` = 0
  - latched request = 0
- Reset mid-operation (BUSY or ACK): return to IDLE on that edge, no write committed, `data_o` cleared.
- Latency: request accepted at edge t0 gives `ack_o` high exactly during cycle [t0+`LATENCY`, t0+`LATENCY`+1).
  - Read data is valid on `data_o` from that same cycle onward.
- Earliest next acceptance is edge t0+`LATENCY`+2. This leaves one dead cycle (the ACK state).
- The cache's write-back-then-refill sequence keeps `enable_i` high across the ack. With `write_i` dropping to 0 at the ack edge, the refill is accepted at t0+`LATENCY`+2 with no lost request.
- The cache samples refill data one cycle after `ack_o`. `data_o` holds stable until the next read completes, so this is safe.
- Throughput is one line per `LATENCY`+2 cycles.

## Structure
- Shared package `dmem_pkg`:
  - `LINE_W` = 256, `OFFSET_W` = 5
  - state typedef/encoding (IDLE, BUSY, ACK)
  - default `LATENCY` and `DEPTH` constants, reused by the cache bench
- One sub-module: `dmem_line_array`, a synchronous single-port `DEPTH` x 256 array.
  - Inputs: write enable, index, write data. Output: registered read data.
  - The FSM drives it only on the BUSY→ACK edge.
- Top level holds the FSM, the counter and the request latch.

## Test plan
- Write then read:
  - Stimulus: write line 0xA5A5…A5 to address 0x0000_0040, then read 0x0000_0040.
  - Required: read `ack_o` pulses once, `data_o` = 0xA5A5…A5; `data_o` is unchanged after the write ack.
- Latency:
  - Stimulus: `LATENCY`=10, `enable_i` rises before edge t0.
  - Required: `ack_o` high only in cycle t0+10; repeat with `LATENCY`=1 and check ack in cycle t0+1.
- Write-back then refill:
  - Stimulus: hold `enable_i` high, `write_i`=1 to 0x0000_0400 (data 0x1…1), drop `write_i` at the ack edge, keep `enable_i` high.
  - Required: second ack at t0+22; `data_o` = 0x1…1.
- Input churn:
  - Stimulus: during BUSY, change `addr_i` to 0x80 and `data_i` to 0; also drop `enable_i` mid-BUSY on a separate request.
  - Required: the latched address and data are used; ack still issued.
- Reset mid-BUSY:
  - Stimulus: assert `rst_i`=0 at cycle t0+5 of a write to 0x20 (data 0xFF…FF).
  - Required: no ack, `data_o`=0, and a later read of 0x20 does not return 0xFF…FF (prewrite 0x0 first).
- Wrap:
  - Stimulus: `DEPTH`=512, write to 0x0000_4000, then read 0x0000_0000.
  - Required: same data returned.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and types for the line-granular data memory
//                model and its users (cache benches reuse the defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Line geometry: 256-bit lines, byte offset within a line is 5 bits.
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;

  // Default model configuration.
  localparam int DMEM_LATENCY = 10;
  localparam int DMEM_DEPTH   = 512;

  // Request sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;

  // Latency countdown width; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_line_array
//  Description : Synchronous single-port DEPTH x 256-bit line store with a
//                registered read port. Storage is never cleared; only the
//                read register resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] rdata_d;
  logic [LINE_W-1:0] rdata_q;

  // Read register only updates on a read access; it holds across writes.
  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem[idx_i];
    end
  end

  // Line storage: written on an enabled write access, no reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  // Read data register, cleared by the active-low synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_line_array
`default_nettype wire

// File: rtl/data_memory_line.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_line
//  Description : Off-chip data memory model for the cache refill/write-back
//                path. Accepts one line request, completes it after LATENCY
//                cycles with a one-cycle ack, then spends one dead cycle in
//                ACK before accepting again.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_line
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY,
  parameter int DEPTH   = DMEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam int               CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              ack_d, ack_q;
  logic              req_write_d, req_write_q;
  logic [IDX_W-1:0]  req_idx_d, req_idx_q;
  logic [LINE_W-1:0] req_data_d, req_data_q;
  logic              mem_en;

  // Byte offset and bits above the line index play no part in addressing,
  // which is what makes out-of-range addresses wrap onto low lines.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // Next-state, countdown, request latch and array strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    req_write_d = req_write_q;
    req_idx_d   = req_idx_q;
    req_data_d  = req_data_q;
    mem_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d     = ST_BUSY;
          cnt_d       = CNT_LOAD;
          req_write_d = write_i;
          req_idx_d   = addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
          req_data_d  = data_i;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          // A reset on this same edge must not let the access commit.
          mem_en  = rst_i;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, ack and request latch registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      req_write_q <= req_write_d;
      req_idx_q   <= req_idx_d;
      req_data_q  <= req_data_d;
    end
  end

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (mem_en),
    .we_i    (req_write_q),
    .idx_i   (req_idx_q),
    .wdata_i (req_data_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule : data_memory_line
`default_nettype wire

// File: tb/tb_data_memory_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_line
//  Description : Directed self-checking bench for data_memory_line, using a
//                LATENCY=10 instance and a LATENCY=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_line;
  import dmem_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         wr;
  logic         en;
  logic         en1;
  logic         ack;
  logic         ack1;
  logic [255:0] dout;
  logic [255:0] dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_line #(.LATENCY(10), .DEPTH(512)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
    .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout)
  );

  data_memory_line #(.LATENCY(1), .DEPTH(512)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
    .enable_i(en1), .write_i(wr), .ack_o(ack1), .data_o(dout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; enable drops right after acceptance. With churn set,
  // addr/data/write are scrambled while the request is in flight.
  task automatic do_op(input string tag, input bit sel1, input bit w,
                       input logic [31:0] a, input logic [255:0] d, input bit churn);
    int lat;
    int pulses;
    int at;
    lat    = sel1 ? 1 : 10;
    pulses = 0;
    at     = -1;
    addr   = a;
    wdata  = d;
    wr     = w;
    if (sel1) en1 = 1'b1; else en = 1'b1;
    tick;
    en  = 1'b0;
    en1 = 1'b0;
    if (churn) begin
      addr  = 32'h0000_0080;
      wdata = '0;
      wr    = ~w;
    end
    for (int i = 1; i <= lat + 2; i++) begin
      tick;
      if ((sel1 ? ack1 : ack) === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    check({tag, " ack pulses"}, 256'(pulses), 256'd1);
    check({tag, " ack cycle"}, 256'(at), 256'(lat));
  endtask

  initial begin
    int pulses;
    int first;
    int second;

    rst_n = 1'b0;
    en    = 1'b0;
    en1   = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    tick;
    tick;
    check("reset ack", {255'd0, ack}, 256'd0);
    check("reset data", dout, 256'd0);
    check("reset ack1", {255'd0, ack1}, 256'd0);
    rst_n = 1'b1;
    tick;

    // Write then read.
    do_op("wr40", 1'b0, 1'b1, 32'h0000_0040, {32{8'hA5}}, 1'b0);
    check("data after write", dout, 256'd0);
    do_op("rd40", 1'b0, 1'b0, 32'h0000_0040, '0, 1'b0);
    check("rd40 data", dout, {32{8'hA5}});

    // Input churn during BUSY; enable already dropped mid-BUSY.
    do_op("wr80", 1'b0, 1'b1, 32'h0000_0080, {32{8'h77}}, 1'b0);
    do_op("wr100 churn", 1'b0, 1'b1, 32'h0000_0100, {32{8'hC3}}, 1'b1);
    do_op("rd80", 1'b0, 1'b0, 32'h0000_0080, '0, 1'b0);
    check("rd80 data", dout, {32{8'h77}});
    do_op("rd100", 1'b0, 1'b0, 32'h0000_0100, '0, 1'b0);
    check("rd100 data", dout, {32{8'hC3}});
    do_op("rd40 churn", 1'b0, 1'b0, 32'h0000_0040, '0, 1'b1);
    check("rd40 churn data", dout, {32{8'hA5}});

    // Write-back then refill with enable held across the ack.
    addr   = 32'h0000_0400;
    wdata  = {64{4'h1}};
    wr     = 1'b1;
    en     = 1'b1;
    tick;
    pulses = 0;
    first  = -1;
    second = -1;
    for (int i = 1; i <= 24; i++) begin
      tick;
      if (ack === 1'b1) begin
        pulses++;
        if (first < 0) first = i; else second = i;
        wr = 1'b0;
      end
      if (i == 12) en = 1'b0;
    end
    check("wbrf pulses", 256'(pulses), 256'd2);
    check("wbrf first ack", 256'(first), 256'd10);
    check("wbrf second ack", 256'(second), 256'd22);
    check("wbrf data", dout, {64{4'h1}});

    // Reset in the middle of a write.
    do_op("prewr20", 1'b0, 1'b1, 32'h0000_0020, '0, 1'b0);
    addr  = 32'h0000_0020;
    wdata = '1;
    wr    = 1'b1;
    en    = 1'b1;
    tick;
    en = 1'b0;
    for (int i = 1; i <= 4; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rst mid data", dout, 256'd0);
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      tick;
      if (ack === 1'b1) pulses++;
    end
    check("rst mid no ack", 256'(pulses), 256'd0);
    do_op("rd20", 1'b0, 1'b0, 32'h0000_0020, '0, 1'b0);
    check("rd20 data", dout, 256'd0);

    // Address wrap: line 512 aliases line 0.
    do_op("wr4000", 1'b0, 1'b1, 32'h0000_4000, {8{32'hDEADBEEF}}, 1'b0);
    do_op("rd0", 1'b0, 1'b0, 32'h0000_0000, '0, 1'b0);
    check("wrap data", dout, {8{32'hDEADBEEF}});

    // Minimum latency instance.
    do_op("l1 wr40", 1'b1, 1'b1, 32'h0000_0040, {32{8'h3C}}, 1'b0);
    check("l1 data after write", dout1, 256'd0);
    do_op("l1 rd40", 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0);
    check("l1 rd40 data", dout1, {32{8'h3C}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_data_memory_line
`default_nettype wire
